cd_spi_csr_bridge: RTL

- SPI slave (mode 0, MSB first) that acts as the initiator on the 5-bit-address / 8-bit-data CSR bus of the cdbus top, allowing an external MCU to reach cdbus registers over SPI.
- Oversamples SCLK/NSS/MOSI in the system clock domain and turns each SPI frame into single-cycle csr_read / csr_write strobes.
- Sits between the board SPI pins and the cdbus csr_* and chip_select inputs.

---
 rtl/cd_spi_csr_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cd_spi_csr_bridge.sv
// rtl/cd_spi_csr_bridge.sv - SPI mode-0 slave that initiates single-cycle CSR reads/writes
//
// Ports:
//   clk, reset_n          system clock (>= 6x sclk), asynchronous active-low reset
//   sclk, nss, mosi       raw SPI inputs from the board, synchronized internally
//   miso, miso_oe         SPI data to the master and its output enable
//   csr_address           5-bit CSR address, fixed per frame (or incrementing, see below)
//   csr_read, csr_readdata    one-clk read strobe; data sampled on the following clk
//   csr_write, csr_writedata  one-clk write strobe with its data
//   chip_select           high from header read-decode until nss deasserts
//
// Parameter SYNC_STAGES (>= 2): synchronizer depth on sclk, nss and mosi.
// Optional macro CD_SPI_AUTO_INC_EN: csr_address increments (wrapping 31->0)
// after every csr_read / csr_write strobe within a frame.

module cd_spi_csr_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata,
    output logic       chip_select
);

    typedef enum logic [1:0] {IDLE, HEADER, WRITE, READ} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   nss_prev_q, nss_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [4:0]             csr_address_q, csr_address_d;
    logic                   csr_read_q, csr_read_d;
    logic                   csr_write_q, csr_write_d;
    logic [7:0]             csr_writedata_q, csr_writedata_d;
    logic                   chip_select_q, chip_select_d;

    logic       sclk_s, nss_s, mosi_s;
    logic       sclk_rise, sclk_fall, nss_fall, nss_rise;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign nss_s     = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign nss_fall  = ~nss_s & nss_prev_q;
    assign nss_rise  = nss_s & ~nss_prev_q;
    // Byte as it will stand once the current rising edge's bit is shifted in.
    assign rx_byte   = {rx_shift_q, mosi_s};

    always_comb begin
        sclk_sync_d     = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        nss_sync_d      = {nss_sync_q[SYNC_STAGES-2:0], nss};
        mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d     = sclk_s;
        nss_prev_d      = nss_s;
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        miso_d          = miso_q;
        miso_oe_d       = miso_oe_q;
        csr_address_d   = csr_address_q;
        csr_read_d      = 1'b0;
        csr_write_d     = 1'b0;
        csr_writedata_d = csr_writedata_q;
        chip_select_d   = chip_select_q;

`ifdef CD_SPI_AUTO_INC_EN
        if (csr_read_q || csr_write_q) begin
            csr_address_d = csr_address_q + 5'd1;
        end
`endif

        // Read data arrives the clk after the strobe; a read still in flight
        // when the frame aborts finds the FSM in IDLE and is discarded.
        if (csr_read_q && state_q == READ) begin
            tx_shift_d = csr_readdata;
        end

        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d   = HEADER;
                    bit_cnt_d = 3'd0;
                    miso_oe_d = 1'b1;
                    miso_d    = 1'b0;
                end
            end
            default: begin
                if (nss_rise) begin
                    // Partial byte is simply abandoned: no strobe is produced.
                    state_d       = IDLE;
                    bit_cnt_d     = 3'd0;
                    miso_oe_d     = 1'b0;
                    miso_d        = 1'b0;
                    chip_select_d = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        rx_shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                HEADER: begin
                                    csr_address_d = rx_byte[4:0];
                                    if (rx_byte[7]) begin
                                        state_d = WRITE;
                                    end else begin
                                        csr_read_d    = 1'b1;
                                        chip_select_d = 1'b1;
                                        state_d       = READ;
                                    end
                                end
                                WRITE: begin
                                    csr_write_d     = 1'b1;
                                    csr_writedata_d = rx_byte;
                                end
                                default: begin
                                    // Prefetch for the byte that follows.
                                    csr_read_d = 1'b1;
                                end
                            endcase
                        end
                    end
                    // The 8th fall of each byte presents the MSB of the freshly
                    // loaded read data; the next seven falls shift out the rest.
                    if (sclk_fall && state_q == READ) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // nss is held "low" in reset so a frame already in progress at
            // reset release never produces a falling edge; nss must be seen
            // high first.
            sclk_sync_q     <= '0;
            nss_sync_q      <= '0;
            mosi_sync_q     <= '0;
            sclk_prev_q     <= 1'b0;
            nss_prev_q      <= 1'b0;
            state_q         <= IDLE;
            bit_cnt_q       <= 3'd0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            miso_q          <= 1'b0;
            miso_oe_q       <= 1'b0;
            csr_address_q   <= '0;
            csr_read_q      <= 1'b0;
            csr_write_q     <= 1'b0;
            csr_writedata_q <= '0;
            chip_select_q   <= 1'b0;
        end else begin
            sclk_sync_q     <= sclk_sync_d;
            nss_sync_q      <= nss_sync_d;
            mosi_sync_q     <= mosi_sync_d;
            sclk_prev_q     <= sclk_prev_d;
            nss_prev_q      <= nss_prev_d;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            miso_q          <= miso_d;
            miso_oe_q       <= miso_oe_d;
            csr_address_q   <= csr_address_d;
            csr_read_q      <= csr_read_d;
            csr_write_q     <= csr_write_d;
            csr_writedata_q <= csr_writedata_d;
            chip_select_q   <= chip_select_d;
        end
    end

    assign miso          = miso_q;
    assign miso_oe       = miso_oe_q;
    assign csr_address   = csr_address_q;
    assign csr_read      = csr_read_q;
    assign csr_write     = csr_write_q;
    assign csr_writedata = csr_writedata_q;
    assign chip_select   = chip_select_q;

endmodule
